adc_cmd_arbiter: RTL

//  Shares the adc_control PROGRAM command path among NUM_REQ requesters (EBI host, sequencer, calibration).

---
 rtl/adc_cmd_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/adc_cmd_arbiter.sv
// Round-robin arbiter writing one requester's ADC command to PROGRAM, then polling LAST until executed; ack 4+POLL_GAP clks after req is seen.
// Losers hold req until ack, with no preemption. ADC_CMD_TIMEOUT_EN adds a TIMEOUT poll limit (ack+err on abort); otherwise err=0.
module adc_cmd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int POLL_GAP    = 8,
  parameter int ADC_CHANNEL = 0,
  parameter int TIMEOUT     = 4095
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   err,
  output logic                   busy,
  output logic [18:0]            adc_addr,
  output logic [15:0]            adc_wdata,
  output logic                   adc_enable,
  output logic                   adc_wr,
  output logic                   adc_re,
  input  logic [15:0]            adc_rdata
);

  localparam int         IW         = $clog2(NUM_REQ);
  localparam logic [3:0] OP_PROGRAM = 4'h4;
  localparam logic [3:0] OP_LAST    = 4'hB;
  localparam logic [10:0] CHAN      = 11'(ADC_CHANNEL);
  localparam logic [7:0] GAP_END    = 8'(POLL_GAP - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || POLL_GAP < 1 || POLL_GAP > 255 ||
      ADC_CHANNEL < 0 || ADC_CHANNEL > 2047 || TIMEOUT < 1 || TIMEOUT > 4095) begin : g_param_check
    $error("adc_cmd_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, ARB, WRITE, GAP, RD, CHK, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, gnt_q, gnt_sel, idx;
  logic            found;
  logic [15:0]     cmd_q;
  logic [15:0]     cmd_arr [NUM_REQ];
  logic [7:0]      gap_cnt;
`ifdef ADC_CMD_TIMEOUT_EN
  localparam logic [11:0] TIMEOUT_END = 12'(TIMEOUT - 1);
  logic [11:0]     poll_cnt;
  logic            timeout_hit;
`endif

  assign busy = (state != IDLE);

  // First pending requester at or above the round-robin pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_sel = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cmd_arr[k] = req_cmd[16*k +: 16];
      idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_sel = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef ADC_CMD_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE:  if (|req) state_nxt = ARB;
      ARB:   state_nxt = found ? WRITE : IDLE;
      WRITE: state_nxt = GAP;
      GAP:   if (gap_cnt == GAP_END) state_nxt = RD;
      RD:    state_nxt = CHK;
      CHK: begin
        if (adc_rdata == cmd_q) begin
          state_nxt = DONE;
        end else begin
`ifdef ADC_CMD_TIMEOUT_EN
          if (poll_cnt == TIMEOUT_END) begin
            state_nxt   = DONE;
            timeout_hit = 1'b1;
          end else begin
            state_nxt = GAP;
          end
`else
          state_nxt = GAP;
`endif
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_q   <= '0;
      cmd_q   <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (state == ARB && found) begin
        gnt_q  <= gnt_sel;
        cmd_q  <= cmd_arr[gnt_sel];
        rr_ptr <= (gnt_sel == IW'(NUM_REQ - 1)) ? '0 : gnt_sel + IW'(1);
      end
    end
  end

`ifdef ADC_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= timeout_hit;
      if (state == ARB)
        poll_cnt <= '0;
      else if (state == CHK && adc_rdata != cmd_q)
        poll_cnt <= poll_cnt + 12'd1;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Bus and ack registers are loaded from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack        <= '0;
      adc_addr   <= '0;
      adc_wdata  <= '0;
      adc_enable <= 1'b0;
      adc_wr     <= 1'b0;
      adc_re     <= 1'b0;
    end else begin
      ack        <= (state_nxt == DONE) ? (NUM_REQ'(1) << gnt_q) : '0;
      adc_wr     <= (state_nxt == WRITE);
      adc_re     <= (state_nxt == RD);
      adc_enable <= (state_nxt == WRITE) || (state_nxt == RD);
      adc_wdata  <= (state_nxt == WRITE) ? cmd_arr[gnt_sel] : 16'h0;
      if (state_nxt == WRITE)
        adc_addr <= {CHAN, 4'h0, OP_PROGRAM};
      else if (state_nxt == RD)
        adc_addr <= {CHAN, 4'h0, OP_LAST};
      else
        adc_addr <= '0;
    end
  end

endmodule
